monobit_bit_source: RTL and testbench
=====================================

Name: monobit_bit_source

Overview:
Serial bit-stream transmitter that produces the epsilon stream consumed by the monobit frequency tester.
- Emits fixed-length blocks of BLOCK_LEN bits over a valid/ready serial handshake.
- Bit sources: internal LFSR, externally fed bytes, or two deterministic patterns.
- Sits in tt_um_monobit between the ui_in/uio_in pins and the tester's epsilon input. Gives on-chip self-test and lets off-chip data be fed in.

Parameters:
BLOCK_LEN, 128, bits per block; >=8, multiple of 8
LFSR_W, 16, LFSR width (fixed polynomial for 16)
SEED, 16'hACE1, LFSR value loaded at reset; must be non-zero

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a block; sampled only in IDLE
mode  in  2  source select, captured at start: 00 LFSR, 01 byte feed, 10 all-ones, 11 alternating
byte_data  in  8  parallel byte for mode 01
byte_valid  in  1  byte_data valid
byte_ready  out  1  block will accept a byte this cycle
epsilon_dat  out  1  serial bit
epsilon_vld  out  1  epsilon_dat valid
epsilon_rdy  in  1  consumer accepts the bit
busy  out  1  block in progress
block_done  out  1  one-cycle pulse after the last bit of a block transfers
bit_count  out  $clog2(BLOCK_LEN+1)  bits transferred in the current block

Behaviour:
Reset: all outputs go to 0.
- State: IDLE; counters 0; LFSR=SEED.

FSM states: IDLE, FETCH, SHIFT, DONE.

IDLE:
- start=1 -> capture mode, busy=1, bit_count=0.
- mode 01 -> FETCH; other modes -> SHIFT.
- start while busy is ignored.

FETCH:
- byte_ready=1.
- On byte_valid&&byte_ready: load the 8-bit shift reg, go to SHIFT.
- epsilon_vld=0 while in FETCH.

SHIFT:
- epsilon_vld=1; epsilon_dat holds the current bit.
- A transfer happens on the edge where epsilon_vld&&epsilon_rdy.
- epsilon_dat and epsilon_vld stay stable while vld&&!rdy.
- On each transfer:
  - bit_count increments.
  - The next bit is presented on the following cycle.
  - No bubble between bits in modes 00/10/11.

Bit sources:
- mode 00: epsilon_dat = lfsr[0].
  - On transfer: lfsr <= {lfsr[0]^lfsr[2]^lfsr[3]^lfsr[5], lfsr[15:1]}.
  - LFSR state persists across blocks and is reseeded only by reset.
- mode 01: bits go out MSB first.
  - After the 8th bit of a byte transfers, go to FETCH (one-cycle minimum bubble) unless the block is complete.
- mode 10: constant 1.
- mode 11: 1,0,1,0,... starting with 1 at every block start.

Block end:
- When the transfer makes bit_count==BLOCK_LEN: go to DONE, epsilon_vld=0 next cycle.
- DONE lasts one cycle: block_done=1, busy=0, then IDLE.
- bit_count holds BLOCK_LEN until the next start.

Latency:
- start at edge k -> epsilon_vld=1 during cycle k+1 (modes 00/10/11).
- Mode 01: byte_ready=1 in cycle k+1; first bit valid the cycle after the byte is accepted.

Boundary conditions:
- byte_ready is 0 outside FETCH; byte_valid outside FETCH is ignored.
- mode changes while busy have no effect.
- Reset mid-block aborts immediately to reset values; no block_done pulse.

Optional Feature:
MONOBIT_ONES_COUNT_EN
- Defined: adds output ones_count [$clog2(BLOCK_LEN+1)] counting transferred 1-bits in the current block.
  - Cleared at start; holds its value after DONE until the next start.
  - Lets the bench cross-check the tester's is_random result.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package monobit_pkg holds:
  - mode enum (MODE_LFSR, MODE_BYTE, MODE_ONES, MODE_ALT);
  - FSM state enum;
  - LFSR tap constants;
  - default SEED.
- Sub-module monobit_lfsr: 16-bit Fibonacci LFSR with seed load on reset, an advance enable, and the output bit.

Test Plan:
1. Reset, mode=00, start pulse, epsilon_rdy=1 -> first bits 1,0 (0xACE1 -> 0x5670); 128 consecutive vld cycles; block_done at cycle 130; bit_count=128.
2. mode=01, feed 0xA5 then 0x3C, ... -> epsilon_dat sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; epsilon_vld low during each FETCH cycle.
3. mode=10 with epsilon_rdy toggling 1,0,1,0 -> each bit held stable during rdy=0; block takes 256 cycles; with MONOBIT_ONES_COUNT_EN, ones_count=128.
4. mode=11 -> 64 ones, 64 zeros, alternating starting with 1; start asserted mid-block is ignored and bit_count is unaffected.
5. rst_n low at bit 50 of a block -> all outputs 0 asynchronously, no block_done; next block in mode 00 restarts from 0xACE1 with first bit 1.
6. mode=01 with byte_valid held low 10 cycles in FETCH -> epsilon_vld=0 and busy=1 throughout; resumes when byte_valid rises.

Source files
------------

// File: rtl/monobit_bit_source_pkg.sv
// Shared types and constants for the monobit bit source.
// Holds the source-mode and FSM-state enums, the LFSR tap mask and default
// seed, and the LFSR step function used by the LFSR sub-module.
package monobit_pkg;

  // Bit source selected when a block starts.
  typedef enum logic [1:0] {
    MODE_LFSR = 2'b00,
    MODE_BYTE = 2'b01,
    MODE_ONES = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

  // Block sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Feedback taps of the 16-bit Fibonacci LFSR: bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One LFSR advance: parity of the tapped bits enters at the MSB.
  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/monobit_bit_source_if.sv
// Handshake bundle between the monobit bit source and its neighbours.
// master: the bit source itself; slave: the pin-side driver / consumer.
// Optional MONOBIT_ONES_COUNT_EN adds the ones_count signal.
interface monobit_bit_source_if #(
  parameter int BLOCK_LEN = 128
) ();
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  logic             start;
  logic [1:0]       mode;
  logic [7:0]       byte_data;
  logic             byte_valid;
  logic             byte_ready;
  logic             epsilon_dat;
  logic             epsilon_vld;
  logic             epsilon_rdy;
  logic             busy;
  logic             block_done;
  logic [CNT_W-1:0] bit_count;
`ifdef MONOBIT_ONES_COUNT_EN
  logic [CNT_W-1:0] ones_count;

  modport master (
    input  start, mode, byte_data, byte_valid, epsilon_rdy,
    output byte_ready, epsilon_dat, epsilon_vld, busy, block_done, bit_count, ones_count
  );
  modport slave (
    output start, mode, byte_data, byte_valid, epsilon_rdy,
    input  byte_ready, epsilon_dat, epsilon_vld, busy, block_done, bit_count, ones_count
  );
`else
  modport master (
    input  start, mode, byte_data, byte_valid, epsilon_rdy,
    output byte_ready, epsilon_dat, epsilon_vld, busy, block_done, bit_count
  );
  modport slave (
    output start, mode, byte_data, byte_valid, epsilon_rdy,
    input  byte_ready, epsilon_dat, epsilon_vld, busy, block_done, bit_count
  );
`endif
endinterface

// File: rtl/monobit_bit_source_lfsr.sv
// 16-bit Fibonacci LFSR for the monobit bit source.
// Loads SEED on reset, advances one step when adv is high, and exposes both
// the current output bit and the bit that will be current after an advance,
// so the parent can register the next serial bit in the same edge.
// The tap polynomial is fixed for LFSR_W = 16.
module monobit_lfsr
  import monobit_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst_n,
  input  logic adv,
  output logic bit_out,
  output logic bit_next
);

  logic [LFSR_W-1:0] state_r;

  // LFSR state register: seed on reset, step on advance, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SEED;
    end else if (adv) begin
      state_r <= lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign bit_out  = state_r[0];
  assign bit_next = state_r[1];

endmodule

// File: rtl/monobit_bit_source.sv
// Serial epsilon-stream source for the monobit frequency tester.
// Emits BLOCK_LEN-bit blocks over a valid/ready serial handshake from one of
// four sources (LFSR, byte feed, all-ones, alternating). All handshake and
// status outputs are registers; the next-cycle values are computed in the
// next-state process so every output is glitch-free and resets to 0.
// Optional MONOBIT_ONES_COUNT_EN adds a count of transferred 1-bits.
module monobit_bit_source
  import monobit_pkg::*;
#(
  parameter int                BLOCK_LEN = 128,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  monobit_bit_source_if.master bus
);

  localparam int               CNT_W    = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  state_e           state_r,  state_s;
  mode_e            mode_r,   mode_s;
  logic [CNT_W-1:0] cnt_r,    cnt_s;
  logic [7:0]       shreg_r,  shreg_s;
  logic [2:0]       nbit_r,   nbit_s;
  logic             vld_r,    vld_s;
  logic             dat_r,    dat_s;
  logic             brdy_r,   brdy_s;
  logic             busy_r,   busy_s;
  logic             done_r,   done_s;
  logic             lfsr_adv_s;
  logic             lfsr_bit_s;
  logic             lfsr_next_s;
  logic             xfer_s;
  logic [CNT_W-1:0] cnt_inc_s;
`ifdef MONOBIT_ONES_COUNT_EN
  logic [CNT_W-1:0] ones_r,   ones_s;
`endif

  monobit_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (lfsr_adv_s),
    .bit_out  (lfsr_bit_s),
    .bit_next (lfsr_next_s)
  );

  assign xfer_s    = vld_r & bus.epsilon_rdy;
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    cnt_s      = cnt_r;
    shreg_s    = shreg_r;
    nbit_s     = nbit_r;
    vld_s      = vld_r;
    dat_s      = dat_r;
    brdy_s     = brdy_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    lfsr_adv_s = 1'b0;
`ifdef MONOBIT_ONES_COUNT_EN
    ones_s     = ones_r;
`endif
    case (state_r)
      ST_IDLE: begin
        brdy_s = 1'b0;
        vld_s  = 1'b0;
        if (bus.start) begin
          mode_s = mode_e'(bus.mode);
          busy_s = 1'b1;
          cnt_s  = CNT_ZERO;
          nbit_s = 3'd0;
`ifdef MONOBIT_ONES_COUNT_EN
          ones_s = CNT_ZERO;
`endif
          case (mode_e'(bus.mode))
            MODE_BYTE: begin
              state_s = ST_FETCH;
              brdy_s  = 1'b1;
            end
            MODE_LFSR: begin
              state_s = ST_SHIFT;
              vld_s   = 1'b1;
              dat_s   = lfsr_bit_s;
            end
            MODE_ONES, MODE_ALT: begin
              // Alternating pattern restarts with a 1 on every block.
              state_s = ST_SHIFT;
              vld_s   = 1'b1;
              dat_s   = 1'b1;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_FETCH: begin
        if (bus.byte_valid && brdy_r) begin
          // MSB goes out first; the remaining seven bits wait in shreg.
          state_s = ST_SHIFT;
          brdy_s  = 1'b0;
          vld_s   = 1'b1;
          dat_s   = bus.byte_data[7];
          shreg_s = {bus.byte_data[6:0], 1'b0};
          nbit_s  = 3'd0;
        end else begin
          brdy_s  = 1'b1;
          vld_s   = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (xfer_s) begin
          cnt_s      = cnt_inc_s;
          lfsr_adv_s = (mode_r == MODE_LFSR);
`ifdef MONOBIT_ONES_COUNT_EN
          ones_s     = ones_r + CNT_W'(dat_r);
`endif
          if (cnt_inc_s == LAST_CNT) begin
            state_s = ST_DONE;
            vld_s   = 1'b0;
            dat_s   = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            case (mode_r)
              MODE_LFSR: begin
                dat_s = lfsr_next_s;
              end
              MODE_BYTE: begin
                if (nbit_r == 3'd7) begin
                  // Byte exhausted: drop valid and ask for the next byte.
                  state_s = ST_FETCH;
                  vld_s   = 1'b0;
                  brdy_s  = 1'b1;
                end else begin
                  dat_s   = shreg_r[7];
                  shreg_s = {shreg_r[6:0], 1'b0};
                  nbit_s  = nbit_r + 3'd1;
                end
              end
              MODE_ONES: begin
                dat_s = 1'b1;
              end
              MODE_ALT: begin
                dat_s = ~dat_r;
              end
              default: begin
                dat_s = dat_r;
              end
            endcase
          end
        end else begin
          // Stall: keep the presented bit and valid stable.
          state_s = ST_SHIFT;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
        vld_s   = 1'b0;
        brdy_s  = 1'b0;
      end

      default: begin
        state_s = ST_IDLE;
        vld_s   = 1'b0;
        brdy_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears every output to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      mode_r  <= MODE_LFSR;
      cnt_r   <= CNT_ZERO;
      shreg_r <= 8'h00;
      nbit_r  <= 3'd0;
      vld_r   <= 1'b0;
      dat_r   <= 1'b0;
      brdy_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      shreg_r <= shreg_s;
      nbit_r  <= nbit_s;
      vld_r   <= vld_s;
      dat_r   <= dat_s;
      brdy_r  <= brdy_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

`ifdef MONOBIT_ONES_COUNT_EN
  // Ones counter register: cleared at start, holds after the block ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_r <= CNT_ZERO;
    end else begin
      ones_r <= ones_s;
    end
  end

  assign bus.ones_count = ones_r;
`endif

  assign bus.byte_ready  = brdy_r;
  assign bus.epsilon_dat = dat_r;
  assign bus.epsilon_vld = vld_r;
  assign bus.busy        = busy_r;
  assign bus.block_done  = done_r;
  assign bus.bit_count   = cnt_r;

endmodule

// File: tb/tb_monobit_bit_source.sv
// Self-checking bench for monobit_bit_source.
// A per-block queue of expected bits (built from the source rules) is checked
// on every transfer by a monitor; directed tests pin timing and literals.
module tb_monobit_bit_source;

  localparam int          BLOCK_LEN = 128;
  localparam int          CNT_W     = $clog2(BLOCK_LEN + 1);
  localparam logic [15:0] SEED      = 16'hACE1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  monobit_bit_source_if #(.BLOCK_LEN(BLOCK_LEN)) bus ();

  monobit_bit_source #(
    .BLOCK_LEN (BLOCK_LEN),
    .LFSR_W    (16),
    .SEED      (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          exp_q[$];
  logic [7:0]  feed_q[$];
  logic        got_bits[BLOCK_LEN];
  int          xfers    = 0;
  int          ones     = 0;
  bit          chk_en   = 1'b0;
  logic [15:0] model_lfsr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // LFSR rule: shift right, new MSB is bit0^bit2^bit3^bit5.
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  task automatic push_lfsr_block();
    for (int i = 0; i < BLOCK_LEN; i++) begin
      exp_q.push_back(model_lfsr[0]);
      model_lfsr = model_step(model_lfsr);
    end
  endtask

  task automatic queue_bytes(input logic [7:0] b);
    feed_q.push_back(b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  // Per-cycle checker: transferred bits, stall stability, FETCH, block end.
  task automatic monitor_loop();
    bit   prev_stall = 1'b0;
    logic prev_dat   = 1'b0;
    bit   prev_busy  = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (bus.busy && !prev_busy) begin
          xfers = 0;
          ones  = 0;
        end
        if (bus.byte_ready) check("fetch_vld_low", 32'(bus.epsilon_vld), 32'd0);
        if (prev_stall) begin
          check("stall_vld", 32'(bus.epsilon_vld), 32'd1);
          check("stall_dat", 32'(bus.epsilon_dat), 32'(prev_dat));
        end
        if (bus.epsilon_vld && bus.epsilon_rdy) begin
          check("bit_count", 32'(bus.bit_count), 32'(xfers));
          if (exp_q.size() == 0) begin
            check("unexpected_bit", 32'(xfers), 32'(BLOCK_LEN));
          end else begin
            check("epsilon_dat", 32'(bus.epsilon_dat), 32'(exp_q.pop_front()));
          end
          if (xfers < BLOCK_LEN) got_bits[xfers] = bus.epsilon_dat;
          xfers++;
          ones += int'(bus.epsilon_dat);
        end
        if (bus.block_done) begin
          check("done_xfers", 32'(xfers), 32'(BLOCK_LEN));
          check("done_busy", 32'(bus.busy), 32'd0);
          check("done_count", 32'(bus.bit_count), 32'(BLOCK_LEN));
`ifdef MONOBIT_ONES_COUNT_EN
          check("done_ones", 32'(bus.ones_count), 32'(ones));
`endif
        end
        prev_stall = bus.epsilon_vld && !bus.epsilon_rdy;
        prev_dat   = bus.epsilon_dat;
        prev_busy  = bus.busy;
      end else begin
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    check({name, "_vld"}, 32'(bus.epsilon_vld), 32'd0);
    check({name, "_dat"}, 32'(bus.epsilon_dat), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.block_done), 32'd0);
    check({name, "_count"}, 32'(bus.bit_count), 32'd0);
  endtask

  // Runs one block; cycle 1 is the cycle start is driven. Returns the cycle
  // in which block_done is seen (0 if aborted or timed out).
  task automatic run_block(input logic [1:0] m, input bit toggle, input int inject_c,
                           input int stall_until, input int abort_c, output int done_c);
    int c;
    bit hs;
    done_c = 0;
    @(posedge clk); #1;
    bus.mode  = m;
    bus.start = 1'b1;
    c = 1;
    if (feed_q.size() > 0 && stall_until == 0) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = feed_q[0];
    end
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      hs = bus.byte_ready && bus.byte_valid;
      if (bus.block_done) begin
        done_c = c;
        break;
      end
      if (stall_until > 0 && c >= 2 && c <= stall_until) begin
        check("stall_fetch_busy", 32'(bus.busy), 32'd1);
        check("stall_fetch_rdy", 32'(bus.byte_ready), 32'd1);
        check("stall_fetch_vld", 32'(bus.epsilon_vld), 32'd0);
      end
      @(posedge clk); #1;
      c++;
      bus.start = (c == inject_c);
      if (c == inject_c) bus.mode = 2'b01;
      bus.epsilon_rdy = toggle ? (c % 2 == 0) : 1'b1;
      if (hs) void'(feed_q.pop_front());
      if (feed_q.size() > 0 && c > stall_until) begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = feed_q[0];
      end else begin
        bus.byte_valid = 1'b0;
      end
      if (c == abort_c) begin
        check("abort_bit_count", 32'(bus.bit_count), 32'd50);
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("abort");
        break;
      end
    end
    if (done_c == 0 && abort_c == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL block_timeout: got no block_done required one (mode %0d)", m);
    end
  endtask

  initial begin
    int dc;
    int cnt1;
    logic [15:0] word;
    bus.start       = 1'b0;
    bus.mode        = 2'b00;
    bus.byte_data   = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.epsilon_rdy = 1'b1;
    model_lfsr      = SEED;
    fork
      monitor_loop();
    join_none

    // Reset state.
    #1 rst_n = 1'b0;
    #11 check_all_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: LFSR block, rdy always high.
    check("model_step", 32'(model_step(SEED)), 32'h5670);
    push_lfsr_block();
    run_block(2'b00, 1'b0, 0, 0, 0, dc);
    check("t1_done_cycle", 32'(dc), 32'd130);
    check("t1_bit0", 32'(got_bits[0]), 32'd1);
    check("t1_bit1", 32'(got_bits[1]), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_count_hold", 32'(bus.bit_count), 32'(BLOCK_LEN));
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // 2: byte feed 0xA5, 0x3C, then 14 more bytes.
    queue_bytes(8'hA5);
    queue_bytes(8'h3C);
    for (int i = 0; i < 14; i++) queue_bytes(8'(i * 29 + 7));
    run_block(2'b01, 1'b0, 0, 0, 0, dc);
    for (int i = 0; i < 16; i++) word[15-i] = got_bits[i];
    check("t2_first16", 32'(word), 32'h0000A53C);
    check("t2_done_cycle", 32'(dc), 32'd146);

    // 3: all-ones, rdy toggling.
    for (int i = 0; i < BLOCK_LEN; i++) exp_q.push_back(1'b1);
    run_block(2'b10, 1'b1, 0, 0, 0, dc);
    check("t3_done_cycle", 32'(dc), 32'd257);
`ifdef MONOBIT_ONES_COUNT_EN
    check("t3_ones_count", 32'(bus.ones_count), 32'd128);
`endif

    // 4: alternating, start + mode change injected mid-block.
    for (int i = 0; i < BLOCK_LEN; i++) exp_q.push_back((i % 2) == 0);
    run_block(2'b11, 1'b0, 60, 0, 0, dc);
    check("t4_done_cycle", 32'(dc), 32'd130);
    cnt1 = 0;
    for (int i = 0; i < BLOCK_LEN; i++) cnt1 += int'(got_bits[i]);
    check("t4_ones", 32'(cnt1), 32'd64);
    check("t4_last_bit", 32'(got_bits[BLOCK_LEN-1]), 32'd0);

    // 5: reset at bit 50, then a fresh LFSR block from the seed.
    push_lfsr_block();
    run_block(2'b00, 1'b0, 0, 0, 52, dc);
    exp_q.delete();
    model_lfsr = SEED;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_done", 32'(bus.block_done), 32'd0);
      check("t5_no_busy", 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    push_lfsr_block();
    run_block(2'b00, 1'b0, 0, 0, 0, dc);
    check("t5_restart_bit0", 32'(got_bits[0]), 32'd1);
    check("t5_done_cycle", 32'(dc), 32'd130);

    // 6: byte feed with byte_valid held low for 10 FETCH cycles.
    for (int i = 0; i < 16; i++) queue_bytes(8'(i * 37 + 5));
    run_block(2'b01, 1'b0, 0, 11, 0, dc);
    check("t6_done_cycle", 32'(dc), 32'd156);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
